// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/data memory handshake bundle for the multi-cycle sequencer.
// master = sequencer side, slave = memory side.
interface multicycle_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] instr_in;
    logic                  dmem_req;
    logic                  dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        input  imem_ack,
        input  dmem_ack,
        input  instr_in
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output imem_ack,
        output dmem_ack,
        output instr_in
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer for addi, lw and bne with sticky trap.
// Optional CTRL_PERF_EN macro adds instret/cycles performance counters.
module multicycle_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_if.master     mem,
    input  logic                  eq,
    output logic [DATA_WIDTH-1:0] ir_q,
    output logic                  ImmSrc,
    output logic                  ALUsrc,
    output logic [2:0]            ALUctrl,
    output logic                  RegWrite,
    output logic                  MemToReg,
    output logic                  PCsrc,
    output logic                  pc_en,
    output logic                  trap,
    output logic [1:0]            trap_cause
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]           instret,
    output logic [31:0]           cycles
`endif
);

    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;

    localparam logic [OPC_W-1:0] OPC_ADDI = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LW   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_BNE  = 7'b1100011;
    localparam logic [F3_W-1:0]  F3_ADDI  = 3'b000;
    localparam logic [F3_W-1:0]  F3_LW    = 3'b010;
    localparam logic [F3_W-1:0]  F3_BNE   = 3'b001;

    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    localparam logic [1:0] CAUSE_IMEM    = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [2:0] {
        S_RST_WAIT = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC     = 3'd3,
        S_MEM      = 3'd4,
        S_WB       = 3'd5,
        S_TRAP     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_ADDI = 2'd0,
        OP_LW   = 2'd1,
        OP_BNE  = 2'd2,
        OP_ILL  = 2'd3
    } op_t;

    function automatic op_t classify(input logic [OPC_W-1:0] opc, input logic [F3_W-1:0] f3);
        op_t op;
        op = OP_ILL;
        if (opc == OPC_ADDI && f3 == F3_ADDI) op = OP_ADDI;
        if (opc == OPC_LW   && f3 == F3_LW)   op = OP_LW;
        if (opc == OPC_BNE  && f3 == F3_BNE)  op = OP_BNE;
        return op;
    endfunction

    state_t                state;
    state_t                nxt_state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] nxt_ir;
    logic [1:0]            nxt_cause;
    logic                  timeout_hit;
    op_t                   op_cur;
    op_t                   op_nxt;

    // IR loads only on an accepted fetch; decode looks ahead so outputs register with the state.
    assign nxt_ir      = (state == S_FETCH && mem.imem_ack) ? mem.instr_in : ir_q;
    assign op_cur      = classify(ir_q[6:0], ir_q[14:12]);
    assign op_nxt      = classify(nxt_ir[6:0], nxt_ir[14:12]);
    assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LIMIT);

    // Branch select follows the live ALU flag during EXEC.
    assign PCsrc = (state == S_EXEC) && (op_cur == OP_BNE) && !eq;

    // Next-state selection
    always_comb begin
        nxt_state = state;
        nxt_cause = 2'b00;
        case (state)
            S_RST_WAIT: nxt_state = S_FETCH;
            S_FETCH: begin
                if (mem.imem_ack) begin
                    nxt_state = S_DECODE;
                end else if (timeout_hit) begin
                    nxt_state = S_TRAP;
                    nxt_cause = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                if (op_cur == OP_ILL) begin
                    nxt_state = S_TRAP;
                    nxt_cause = CAUSE_ILLEGAL;
                end else begin
                    nxt_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_cur)
                    OP_ADDI: nxt_state = S_WB;
                    OP_LW:   nxt_state = S_MEM;
                    default: nxt_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem.dmem_ack) begin
                    nxt_state = S_WB;
                end else if (timeout_hit) begin
                    nxt_state = S_TRAP;
                    nxt_cause = CAUSE_DMEM;
                end
            end
            S_WB:    nxt_state = S_FETCH;
            S_TRAP:  nxt_state = S_TRAP;
            default: nxt_state = S_RST_WAIT;
        endcase
    end

    // State, IR, wait counter, trap and registered datapath controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RST_WAIT;
            ir_q         <= '0;
            cnt          <= '0;
            trap         <= 1'b0;
            trap_cause   <= 2'b00;
            mem.imem_req <= 1'b0;
            mem.dmem_req <= 1'b0;
            ImmSrc       <= 1'b1;
            ALUsrc       <= 1'b0;
            ALUctrl      <= ALU_ADD;
            RegWrite     <= 1'b0;
            MemToReg     <= 1'b0;
            pc_en        <= 1'b0;
        end else begin
            state <= nxt_state;
            ir_q  <= nxt_ir;

            // Counter stops at the limit (the state leaves), so it never wraps before comparing.
            if (nxt_state != state) begin
                cnt <= '0;
            end else if (state == S_FETCH || state == S_MEM) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (nxt_state == S_TRAP && state != S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= nxt_cause;
            end

            mem.imem_req <= (nxt_state == S_FETCH);
            mem.dmem_req <= (nxt_state == S_MEM);
            RegWrite     <= (nxt_state == S_WB);
            MemToReg     <= (nxt_state == S_WB) && (op_nxt == OP_LW);
            pc_en        <= (nxt_state == S_WB) ||
                            ((nxt_state == S_EXEC) && (op_nxt == OP_BNE));
            ImmSrc       <= !((nxt_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) &&
                              (op_nxt == OP_BNE));
            ALUsrc       <= (nxt_state inside {S_EXEC, S_MEM}) &&
                            (op_nxt == OP_ADDI || op_nxt == OP_LW);
            ALUctrl      <= ((nxt_state == S_EXEC) && (op_nxt == OP_BNE)) ? ALU_SUB : ALU_ADD;
        end
    end

`ifdef CTRL_PERF_EN
    // Free-running performance counters, frozen cycle count while trapped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles  <= '0;
            instret <= '0;
        end else begin
            if (state != S_TRAP) cycles <= cycles + 32'd1;
            if (pc_en)           instret <= instret + 32'd1;
        end
    end
`endif

endmodule
